// File: rtl/sound_stim_pkg.sv
// sound_stim_pkg: shared states, entry layout helpers, idle levels and CRC for sound_stim_seq
package sound_stim_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_APPLY = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAPS  = 3'd4;
    localparam logic PB_IDLE = 1'b1;
    localparam logic HAND_IDLE = 1'b1;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    function automatic int chan_w(input int channels);
        return channels > 1 ? $clog2(channels) : 1;
    endfunction
    function automatic int pb_lsb(input int cw);
        return cw;
    endfunction
    function automatic int hand_bit(input int cw, input int pb_w);
        return cw + pb_w;
    endfunction
    function automatic int hold_lsb(input int cw, input int pb_w);
        return cw + pb_w + 1;
    endfunction
    function automatic int entry_w(input int cw, input int pb_w, input int hold_w);
        return cw + pb_w + 1 + hold_w;
    endfunction
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) c = c[15] ? {c[14:0], 1'b0} ^ CRC_POLY : {c[14:0], 1'b0};
        return c;
    endfunction
endpackage

// File: rtl/sound_stim_ram.sv
// sound_stim_ram: entry store, one write port and one synchronous read port
module sound_stim_ram #(
    parameter int DEPTH = 16,
    parameter int W = 25,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_cpu,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk_cpu) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/sound_stim_seq.sv
// sound_stim_seq: PB/HAND stimulus sequencer; SOUND_STIM_CAPTURE_EN adds a CRC signature of dac_in
module sound_stim_seq
    import sound_stim_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int PB_W = 6,
    parameter int DEPTH = 16,
    parameter int HOLD_W = 16,
    parameter int TICK_DIV = 894,
    parameter int GAP = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = chan_w(CHANNELS),
    localparam int EW = entry_w(CW, PB_W, HOLD_W)
) (
    input  logic                   clk_cpu,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [EW-1:0]          wr_data,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop,
    input  logic [AW-1:0]          last_idx,
    output logic [CHANNELS*PB_W-1:0] PB_OUT,
    output logic [CHANNELS-1:0]    HAND_OUT,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          cur_idx,
    input  logic [CHANNELS*8-1:0]  dac_in,
    output logic [15:0]            dac_sig
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int PB_LSB = pb_lsb(CW);
    localparam int HAND_BIT = hand_bit(CW, PB_W);
    localparam int HOLD_LSB = hold_lsb(CW, PB_W);
    logic [2:0] state;
    logic [PW-1:0] presc;
    logic [HOLD_W-1:0] cnt;
    logic [CW-1:0] chan;
    logic loop_r, tick;
    logic [EW-1:0] rd_data;
    logic [CW-1:0] e_chan;
    logic [PB_W-1:0] e_pb;
    logic e_hand;
    logic [HOLD_W-1:0] e_hold;
    sound_stim_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
        .clk_cpu (clk_cpu),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (cur_idx),
        .rd_data (rd_data)
    );
    assign e_chan = rd_data[CW-1:0];
    assign e_pb = rd_data[PB_LSB +: PB_W];
    assign e_hand = rd_data[HAND_BIT];
    assign e_hold = rd_data[HOLD_LSB +: HOLD_W];
    assign tick = presc == PW'(TICK_DIV - 1);
    always_ff @(posedge clk_cpu) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            presc <= '0;
            cnt <= '0;
            chan <= '0;
            loop_r <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            cur_idx <= '0;
            PB_OUT <= {CHANNELS*PB_W{PB_IDLE}};
            HAND_OUT <= {CHANNELS{HAND_IDLE}};
        end else begin
            done <= 1'b0;
            presc <= tick ? '0 : presc + PW'(1);
            if (stop) begin
                state <= ST_IDLE;
                busy <= 1'b0;
                PB_OUT <= {CHANNELS*PB_W{PB_IDLE}};
                HAND_OUT <= {CHANNELS{HAND_IDLE}};
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        state <= ST_FETCH;
                        cur_idx <= '0;
                        busy <= 1'b1;
                        loop_r <= loop;
                        presc <= '0;
                    end
                    ST_FETCH: state <= ST_APPLY;
                    ST_APPLY: begin
                        // re-phase the prescaler so every hold/gap is a whole number of ticks
                        presc <= '0;
                        chan <= e_chan;
                        if (32'(e_chan) < CHANNELS) begin
                            PB_OUT[e_chan*PB_W +: PB_W] <= e_pb;
                            HAND_OUT[e_chan] <= e_hand;
                            cnt <= e_hold == '0 ? HOLD_W'(1) : e_hold;
                            state <= ST_HOLD;
                        end else begin
                            cnt <= HOLD_W'(GAP);
                            state <= ST_GAPS;
                        end
                    end
                    ST_HOLD: if (tick) begin
                        if (cnt <= HOLD_W'(1)) begin
                            PB_OUT[chan*PB_W +: PB_W] <= {PB_W{PB_IDLE}};
                            HAND_OUT[chan] <= HAND_IDLE;
                            cnt <= HOLD_W'(GAP);
                            state <= ST_GAPS;
                        end else cnt <= cnt - HOLD_W'(1);
                    end
                    ST_GAPS: if (cnt == '0 || (tick && cnt == HOLD_W'(1))) begin
                        if (cur_idx == last_idx && !loop_r) begin
                            state <= ST_IDLE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            cur_idx <= cur_idx == last_idx ? '0 : cur_idx + AW'(1);
                            state <= ST_FETCH;
                        end
                    end else if (tick) cnt <= cnt - HOLD_W'(1);
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
`ifdef SOUND_STIM_CAPTURE_EN
    logic [CHANNELS*8-1:0] dac_prev;
    logic [15:0] sig_next;
    always_comb begin
        sig_next = dac_sig;
        for (int i = 0; i < CHANNELS; i++)
            if (dac_in[i*8 +: 8] != dac_prev[i*8 +: 8])
                sig_next = crc16_byte(crc16_byte(sig_next, 8'(i)), dac_in[i*8 +: 8]);
    end
    always_ff @(posedge clk_cpu) begin
        if (!reset_n) begin
            dac_prev <= '0;
            dac_sig <= '0;
        end else begin
            dac_prev <= dac_in;
            if (state == ST_IDLE && start && !stop) dac_sig <= CRC_INIT;
            else if (busy) dac_sig <= sig_next;
        end
    end
`else
    logic unused_dac;
    assign unused_dac = ^dac_in;
    assign dac_sig = '0;
`endif
endmodule

// File: tb/tb_sound_stim_seq.sv
// tb_sound_stim_seq: randomized self-checking bench for sound_stim_seq against a timeline model
module tb_sound_stim_seq;
    localparam int CH = 3, PBW = 6, DEP = 16, HW = 16, TD = 4, GP = 2;
    localparam int AW = 4, CW = 2, EW = CW + PBW + 1 + HW;
    localparam int MAXC = 256;
    logic clk_cpu = 0, reset_n = 0, wr_en = 0, start = 0, stop = 0, loop = 0;
    logic [AW-1:0] wr_addr = '0, last_idx = '0;
    logic [EW-1:0] wr_data = '0;
    logic [CH*PBW-1:0] PB_OUT;
    logic [CH-1:0] HAND_OUT;
    logic busy, done;
    logic [AW-1:0] cur_idx;
    logic [CH*8-1:0] dac_in = '0;
    logic [15:0] dac_sig;
    int total = 0, bad = 0;
    int m_hold[DEP], m_hand[DEP], m_pb[DEP], m_chan[DEP];
    logic [CH*PBW-1:0] x_pb[MAXC];
    logic [CH-1:0] x_hand[MAXC];
    logic x_busy[MAXC], x_done[MAXC];
    int x_idx[MAXC];

    sound_stim_seq #(.CHANNELS(CH), .PB_W(PBW), .DEPTH(DEP), .HOLD_W(HW), .TICK_DIV(TD), .GAP(GP)) dut (
        .clk_cpu(clk_cpu), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop(loop), .last_idx(last_idx), .PB_OUT(PB_OUT),
        .HAND_OUT(HAND_OUT), .busy(busy), .done(done), .cur_idx(cur_idx), .dac_in(dac_in), .dac_sig(dac_sig)
    );

    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    // Expected pins per cycle after the start edge: each entry drives its channel from
    // its apply edge for max(hold,1) ticks, then GAP idle ticks, then 2 fetch cycles.
    function automatic void model(input int last, input logic lp, input int ncyc);
        int a = 2, g = 0, idx = 0, from = 0, h = 0;
        for (int k = 0; k < ncyc; k++) begin
            x_pb[k] = '1; x_hand[k] = '1; x_busy[k] = 1'b1; x_done[k] = 1'b0; x_idx[k] = 0;
        end
        while (1) begin
            h = m_hold[idx] == 0 ? 1 : m_hold[idx];
            if (m_chan[idx] < CH) begin
                for (int k = a; k < a + h*TD && k < ncyc; k++) begin
                    x_pb[k][m_chan[idx]*PBW +: PBW] = PBW'(m_pb[idx]);
                    x_hand[k][m_chan[idx]] = 1'(m_hand[idx]);
                end
                g = a + (h + GP)*TD;
            end else g = a + GP*TD;
            for (int k = from; k < g && k < ncyc; k++) x_idx[k] = idx;
            if (idx == last && !lp) begin
                for (int k = g; k < ncyc; k++) begin x_busy[k] = 1'b0; x_idx[k] = idx; end
                if (g < ncyc) x_done[g] = 1'b1;
                break;
            end
            idx = idx == last ? 0 : idx + 1;
            from = g;
            a = g + 2;
            if (g >= ncyc) break;
        end
    endfunction

    function automatic logic [15:0] crc_bits(input logic [47:0] m, input int nbits);
        logic [15:0] c = 16'hFFFF;
        logic fb;
        for (int i = 47; i > 47 - nbits; i--) begin
            fb = c[15] ^ m[i];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic write_entry(input int a, input int hold, input int hand, input int pb, input int chan);
        m_hold[a] = hold; m_hand[a] = hand; m_pb[a] = pb; m_chan[a] = chan;
        @(negedge clk_cpu);
        wr_en = 1; wr_addr = AW'(a);
        wr_data = {HW'(hold), 1'(hand), PBW'(pb), CW'(chan)};
        @(negedge clk_cpu);
        wr_en = 0;
    endtask

    // mode: 0 plain, 1 stop at edge 'at', 2 reset at edge 'at', 3 extra start at edge 'at'
    task automatic run_seq(input string name, input int last, input logic lp, input int ncyc,
                           input int mode, input int at);
        int dones = 0, xd = 0, hold_idx = 0;
        logic [CH*PBW+CH+2+AW-1:0] got, exp;
        model(last, lp, ncyc);
        if (mode == 1 || mode == 2) begin
            hold_idx = mode == 1 ? x_idx[at-1] : 0;
            for (int k = at; k < ncyc; k++) begin
                x_pb[k] = '1; x_hand[k] = '1; x_busy[k] = 1'b0; x_done[k] = 1'b0; x_idx[k] = hold_idx;
            end
        end
        last_idx = AW'(last);
        loop = lp;
        @(negedge clk_cpu);
        start = 1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk_cpu);
            got = {PB_OUT, HAND_OUT, busy, done, cur_idx};
            exp = {x_pb[k], x_hand[k], x_busy[k], x_done[k], AW'(x_idx[k])};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cyc %0d: got %h want %h", name, k, got, exp);
            end
            dones += int'(done);
            xd += int'(x_done[k]);
            start = mode == 3 && k == at - 1;
            stop = mode == 1 && k == at - 1;
            reset_n = !(mode == 2 && k == at - 1);
        end
        total++;
        if (dones != xd) begin
            bad++;
            $display("FAIL %s done_count: got %0d want %0d", name, dones, xd);
        end
        start = 0; reset_n = 1; stop = 1;
        @(negedge clk_cpu);
        stop = 0;
    endtask

    task automatic test_reset;
        reset_n = 0;
        repeat (10) @(negedge clk_cpu);
        total += 6;
        if (PB_OUT !== '1) begin bad++; $display("FAIL reset_pb: got %h want all ones", PB_OUT); end
        if (HAND_OUT !== 3'b111) begin bad++; $display("FAIL reset_hand: got %b want 111", HAND_OUT); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (cur_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d want 0", cur_idx); end
        if (dac_sig !== 16'h0) begin bad++; $display("FAIL reset_sig: got %h want 0", dac_sig); end
        reset_n = 1;
        @(negedge clk_cpu);
    endtask

    task automatic test_single;
        write_entry(0, 3, 0, 6'h3F, 0);
        run_seq("single", 0, 1'b0, 30, 0, 0);
    endtask

    task automatic test_edges;
        write_entry(0, 0, 1, 6'h00, 1);
        write_entry(1, 2, 0, 6'h11, 3);
        write_entry(2, 1, 0, 6'h07, 2);
        run_seq("edges", 2, 1'b0, 50, 0, 0);
    endtask

    task automatic test_loop_stop;
        write_entry(0, 2, 0, 6'h15, 0);
        write_entry(1, 1, 1, 6'h2A, 1);
        run_seq("loop_stop", 1, 1'b1, 70, 1, 54);
    endtask

    task automatic test_back_to_back;
        write_entry(0, 2, 0, 6'h0C, 2);
        write_entry(1, 1, 0, 6'h30, 0);
        run_seq("start_busy", 1, 1'b0, 50, 3, 7);
    endtask

    task automatic test_random;
        int last;
        for (int r = 0; r < 5; r++) begin
            last = $urandom_range(0, 3);
            for (int e = 0; e <= last; e++)
                write_entry(e, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 3));
            dac_in = CH*8'($urandom);
            if (r == 4) run_seq("rand_loop", last, 1'b1, 150, 1, $urandom_range(20, 140));
            else run_seq("rand", last, 1'b0, (last + 1)*22 + 10, 0, 0);
        end
    endtask

    task automatic test_reset_mid_hold;
        write_entry(0, 3, 0, 6'h2D, 1);
        run_seq("reset_hold", 0, 1'b0, 20, 2, 8);
    endtask

    task automatic test_stop_start;
        @(negedge clk_cpu);
        stop = 1; start = 1;
        @(negedge clk_cpu);
        stop = 0; start = 0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({busy, HAND_OUT, PB_OUT} !== {1'b0, 3'b111, 18'h3FFFF}) begin
                bad++;
                $display("FAIL stop_start cyc %0d: got %h want %h", k, {busy, HAND_OUT, PB_OUT}, {1'b0, 3'b111, 18'h3FFFF});
            end
            @(negedge clk_cpu);
        end
    endtask

`ifdef SOUND_STIM_CAPTURE_EN
    task automatic test_capture;
        logic [47:0] msg = {8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'hFF};
        int n = 0;
        write_entry(0, 20, 1, 6'h01, 0);
        last_idx = '0; loop = 0;
        dac_in = 24'h000055;
        repeat (3) @(negedge clk_cpu);
        start = 1;
        @(negedge clk_cpu);
        start = 0;
        repeat (4) @(negedge clk_cpu);
        dac_in[7:0] = 8'h00;
        repeat (4) @(negedge clk_cpu);
        dac_in[7:0] = 8'h80;
        repeat (4) @(negedge clk_cpu);
        total++;
        if (dac_sig !== crc_bits(msg, 32)) begin
            bad++; $display("FAIL cap_mid: got %h want %h", dac_sig, crc_bits(msg, 32));
        end
        dac_in[7:0] = 8'h80;
        repeat (6) @(negedge clk_cpu);
        total++;
        if (dac_sig !== crc_bits(msg, 32)) begin
            bad++; $display("FAIL cap_repeat: got %h want %h", dac_sig, crc_bits(msg, 32));
        end
        dac_in[7:0] = 8'hFF;
        while (busy && n < 300) begin @(negedge clk_cpu); n++; end
        total++;
        if (busy) begin bad++; $display("FAIL cap_wait: busy got 1 want 0"); end
        dac_in[7:0] = 8'h42;
        repeat (3) @(negedge clk_cpu);
        total++;
        if (dac_sig !== crc_bits(msg, 48)) begin
            bad++; $display("FAIL cap_final: got %h want %h", dac_sig, crc_bits(msg, 48));
        end
    endtask
`else
    task automatic test_capture;
        write_entry(0, 1, 0, 6'h05, 0);
        dac_in = 24'h123456;
        fork
            run_seq("nocap", 0, 1'b0, 20, 0, 0);
            repeat (10) begin @(negedge clk_cpu); dac_in = 24'($urandom); end
        join
        total++;
        if (dac_sig !== 16'h0) begin bad++; $display("FAIL nocap_sig: got %h want 0", dac_sig); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_edges;
        test_loop_stop;
        test_back_to_back;
        test_random;
        test_reset_mid_hold;
        test_stop_start;
        test_capture;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
